imem_boot_loader: RTL
=====================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 10, instruction-memory word-address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  32  word written.
REQ-011 core_rst  output  1  reset to the downstream processor core.
REQ-012 busy, done, error  output  1 each  status flags.

Function
REQ-013 The FSM SHALL have states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
REQ-014 Stream format SHALL be: length N as 16-bit little-endian (LEN_LO, then LEN_HI), then 4*N payload bytes, then one checksum byte.
REQ-015 in_ready SHALL be 1 only in LEN_LO, LEN_HI, DATA, CSUM; bytes offered in any other state SHALL NOT be consumed.
REQ-016 IDLE + start -> LEN_LO, clearing word index, byte index and checksum accumulator.
REQ-017 After LEN_HI accept: N==0 or N > 2^ADDR_W -> ERR; otherwise -> DATA.
REQ-018 Payload bytes SHALL be packed little-endian: byte k (0..3) of a word into bits [8k+7:8k].
REQ-019 Cycle after the 4th byte of a word is accepted, imem_we SHALL be 1 for exactly one cycle with imem_addr = word index (from 0) and imem_wdata = assembled word; word index then increments.
REQ-020 Accepting the 4th byte of word N-1 SHALL move DATA -> CSUM; in_ready may be 1 in CSUM while that final write is in progress.
REQ-021 Checksum SHALL be XOR of all payload bytes (length and checksum bytes excluded).
REQ-022 CSUM accept: byte == accumulator -> DONE; else -> ERR.
REQ-023 core_rst SHALL be 1 in every state except DONE; 0 in DONE.
REQ-024 busy SHALL be 1 in LEN_LO, LEN_HI, DATA, CSUM; done = 1 only in DONE; error = 1 only in ERR.
REQ-025 start SHALL be ignored while busy and in DONE; DONE holds until rst.
REQ-026 ERR + start -> LEN_LO (retry, counters cleared, error drops next cycle).
REQ-027 imem_addr and imem_wdata SHALL be registered; value when imem_we=0 is don't-care.

Reset
REQ-028 rst SHALL force IDLE, in_ready=0, imem_we=0, core_rst=1, busy=0, done=0, error=0, counters and checksum cleared.
REQ-029 rst mid-load SHALL discard any partial word; no imem_we SHALL be issued in the cycle after rst is sampled.

Verification
REQ-030 start; bytes 02 00 13 00 00 00 93 00 10 00 90 -> write addr 0 = 0x00000013, addr 1 = 0x00100093, done=1, core_rst=0.
REQ-031 Same stream with checksum 0x91 -> two writes, error=1, core_rst=1; then start + correct stream -> done=1.
REQ-032 Length 00 00 -> error=1 after 2nd byte, no writes; length 01 04 (N=1025, ADDR_W=10) -> error=1.
REQ-033 Stream of REQ-030 with in_valid low every other cycle, plus in_valid=1 in IDLE before start -> identical writes; IDLE bytes not consumed.
REQ-034 rst asserted after 6 payload bytes of REQ-030 -> all outputs at reset values, only addr 0 written; restart completes to done=1.
REQ-035 start pulsed during DATA -> ignored, load completes unchanged.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// little-endian 32-bit words into instruction memory, holding the core in reset until done.
module imem_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state;
  logic [7:0]        len_lo;
  logic [15:0]       last_word;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [7:0]        csum;
  logic              accept;
  logic [16:0]       len_full;
  logic              len_bad;
  logic              at_last_word;

  assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CSUM);
  assign busy     = in_ready;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign core_rst = (state != S_DONE);
  assign accept   = in_valid && in_ready;

  // A length equal to the full memory depth is legal; one word more is not.
  assign len_full     = {1'b0, in_data, len_lo};
  assign len_bad      = (len_full == 17'd0) || (len_full > (17'd1 << ADDR_W));
  assign at_last_word = (32'(word_idx) == 32'(last_word));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      last_word  <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            state    <= S_LEN_LO;
            word_idx <= '0;
            byte_idx <= '0;
            csum     <= '0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            last_word <= {in_data, len_lo} - 16'd1;
            state     <= len_bad ? S_ERR : S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            // Bytes shift in from the top so byte 0 lands in bits [7:0].
            word_buf <= {in_data, word_buf[23:8]};
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {in_data, word_buf};
              word_idx   <= word_idx + ADDR_W'(1);
              if (at_last_word) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) state <= (in_data == csum) ? S_DONE : S_ERR;
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
